clk_div_duty_gen: RTL and testbench
===================================

# clk_div_duty_gen

Registered integer clock divider that produces a divided output clock with a programmable high time and start delay. It sits directly upstream of the duty-cycle checker. Its `clk_out` drives the checker's `clk` input and its `LOCKED` drives the checker's `LOCKED` input, so the bench can sweep divide and duty settings deterministically. Settings are loaded at run time through a single-cycle strobe.

## Interface
- `WIDTH`, 8: width of the `divide`, `high_time` and `delay` setting fields.
- `clk` input 1: reference clock; all logic is clocked on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `load` input 1: single-cycle strobe; captures the settings on the rising edge of `clk` where it is high.
- `divide` input WIDTH: output period in `clk` cycles.
- `high_time` input WIDTH: number of `clk` cycles per output period that `clk_out` is high.
- `delay` input WIDTH: number of `clk` cycles between the load edge and the start of the first output period.
- `clk_out` output 1: divided clock, driven directly from a flop.
- `LOCKED` output 1: high once one complete output period has been produced since the last load.
- `err` output 1: only present when `CLK_DIV_ERR_EN` is defined; flags an illegal setting.

## Operation
- State machine states: IDLE, DELAY, RUN.
- Reset (`reset`=0): state IDLE, all counters 0, `clk_out`=0, `LOCKED`=0, `err`=0.
- IDLE:
  - `clk_out`=0 and `LOCKED`=0.
  - Moves to DELAY on `load`.
- `load` in any state:
  - Captures `divide`, `high_time` and `delay` into shadow registers.
  - Clears `LOCKED` on that same edge.
  - Goes to DELAY; when `delay`=0, goes straight to RUN.
  - Settings inputs are ignored whenever `load` is low.
- DELAY:
  - Delay counter runs from 1 up to the shadow `delay` value.
  - `clk_out` holds 0 throughout.
  - Moves to RUN on the edge after the count reaches `delay`.
- RUN:
  - Period counter `cnt` runs 0 .. `divide`-1 and wraps to 0.
  - Registered `clk_out` = (`cnt` < `high_time`), evaluated on the value of `cnt` being entered.
  - `LOCKED` is set on the first wrap of `cnt` to 0 and stays set until the next `load` or reset.
- Width and arithmetic rules:
  - Comparisons are unsigned, WIDTH bits wide.
  - `cnt` and the delay counter are WIDTH bits wide.
  - Overflow cannot occur because `divide` ≤ 2^WIDTH−1.
- Boundary cases:
  - `high_time`=0: `clk_out` stays 0; `LOCKED` still asserts.
  - `high_time`=`divide`: `clk_out` stays 1.
  - `divide`=1 with `high_time`=1: `clk_out` constant 1.
  - `load` in the same cycle as a `cnt` wrap: the load wins; no LOCKED pulse is produced.
  - `load` held high for several cycles: each edge reloads, so the sequence restarts from the last high edge.
  - `reset` asserted mid-operation: immediate asynchronous return to IDLE with all outputs 0.

## Timing
- Number edges from the load edge, E0.
- `clk_out` first rises at edge E(`delay`+1); when `delay`=0, that is E1.
- `clk_out` stays high for `high_time` `clk` periods, then low for `divide`−`high_time` periods.
- Output period is exactly `divide` `clk` periods; duty cycle = `high_time`/`divide`.
- `LOCKED` rises at edge E(`delay`+1+`divide`), i.e. coincident with the second rising edge of `clk_out`.
- `LOCKED` falls at the load edge E0 itself.
- `clk_out` transitions only on rising `clk` edges, with no combinational path from inputs to `clk_out`, so there are no glitches.

## Configuration
- `CLK_DIV_ERR_EN` defined:
  - Adds the `err` port.
  - A load with `divide`=0 or `high_time` > `divide` sets `err`=1 on the load edge and forces IDLE, so `clk_out`=0 and `LOCKED`=0.
  - `err` clears on the next legal load or on reset.
- `CLK_DIV_ERR_EN` undefined:
  - No `err` port.
  - `divide`=0 is clamped to 1 at capture.
  - `high_time` > `divide` is clamped to `divide` at capture.

## Test plan
- Reset with `reset`=0 over 5 `clk` cycles while `load` toggles -> `clk_out`=0 and `LOCKED`=0 throughout; state stays IDLE.
- `load` with `divide`=10, `high_time`=5, `delay`=0 -> `clk_out` rises at E1, high 5 / low 5 cycles, period 10; `LOCKED` rises at E11; the checker configured for 0.5 duty and a 10-cycle period never sets `fail`.
- `load` with `divide`=4, `high_time`=1, `delay`=3 -> `clk_out` low through E3, rises at E4, high 1 / low 3 cycles; `LOCKED` rises at E8.
- While locked at 10/5, `load` with `divide`=6, `high_time`=3, `delay`=2 -> `LOCKED` drops at the load edge, `clk_out` rises at E3 with period 6, `LOCKED` rises at E9.
- `load` with `divide`=3, `high_time`=0, then `load` with `divide`=3, `high_time`=3 -> first load: `clk_out` constant 0; second load: `clk_out` constant 1; `LOCKED` asserts 3 cycles after output start in both cases.
- `load` with `divide`=0, `high_time`=2 -> with `CLK_DIV_ERR_EN`: `err`=1, `clk_out`=0, `LOCKED`=0; without it: treated as `divide`=1, `high_time`=1, giving `clk_out` constant 1 and `LOCKED` at E2.

Source files
------------

// File: rtl/clk_div_duty_gen.sv
// Integer clock divider with programmable high time and start delay; clk_out is a flop output.
// Optional CLK_DIV_ERR_EN adds an err port that rejects illegal settings instead of clamping them.
module clk_div_duty_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] divide,
   input  logic [WIDTH-1:0] high_time,
   input  logic [WIDTH-1:0] delay,
   output logic             clk_out,
   output logic             LOCKED
`ifdef CLK_DIV_ERR_EN
   ,
   output logic             err
`endif
);

   typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] div_s, ht_s, dly_s;
   logic [WIDTH-1:0] cnt, dcnt;
   logic             start;
   logic [WIDTH-1:0] div_c, ht_c, cnt_nxt;
`ifdef CLK_DIV_ERR_EN
   logic             bad_set;
`endif

   always_comb begin
      div_c   = (divide == '0) ? WIDTH'(1) : divide;
      ht_c    = (high_time > div_c) ? div_c : high_time;
      cnt_nxt = (cnt == div_s - WIDTH'(1)) ? '0 : cnt + WIDTH'(1);
`ifdef CLK_DIV_ERR_EN
      bad_set = (divide == '0) || (high_time > divide);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         div_s   <= '0;
         ht_s    <= '0;
         dly_s   <= '0;
         cnt     <= '0;
         dcnt    <= '0;
         start   <= 1'b0;
         clk_out <= 1'b0;
         LOCKED  <= 1'b0;
`ifdef CLK_DIV_ERR_EN
         err     <= 1'b0;
`endif
      end else if (load) begin
         // a load always wins, even over a wrap that would otherwise set LOCKED
         LOCKED  <= 1'b0;
         clk_out <= 1'b0;
         cnt     <= '0;
         dcnt    <= '0;
         div_s   <= div_c;
         ht_s    <= ht_c;
         dly_s   <= delay;
         if (delay == '0) begin
            state <= RUN;
            start <= 1'b1;
         end else begin
            state <= DELAY;
            start <= 1'b0;
         end
`ifdef CLK_DIV_ERR_EN
         err <= bad_set;
         if (bad_set) begin
            state <= IDLE;
            start <= 1'b0;
         end
`endif
      end else begin
         case (state)
            IDLE: begin
               clk_out <= 1'b0;
               LOCKED  <= 1'b0;
            end
            DELAY: begin
               if (dcnt == dly_s) begin
                  state   <= RUN;
                  cnt     <= '0;
                  clk_out <= (ht_s != '0);
               end else begin
                  dcnt <= dcnt + WIDTH'(1);
               end
            end
            RUN: begin
               // start marks the first period entry, which must not count as a wrap
               if (start) begin
                  start   <= 1'b0;
                  cnt     <= '0;
                  clk_out <= (ht_s != '0);
               end else begin
                  cnt     <= cnt_nxt;
                  clk_out <= (cnt_nxt < ht_s);
                  if (cnt_nxt == '0) LOCKED <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_duty_gen.sv
// Scoreboard bench for clk_div_duty_gen: stimulus pushes expected outputs from an
// edge-counting reference model; a monitor pops and compares after each rising edge.
module tb_clk_div_duty_gen;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] divide = '0, high_time = '0, delay = '0;
   logic             clk_out, LOCKED;
`ifdef CLK_DIV_ERR_EN
   logic             err;
`endif

   clk_div_duty_gen #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .load(load),
      .divide(divide), .high_time(high_time), .delay(delay),
      .clk_out(clk_out), .LOCKED(LOCKED)
`ifdef CLK_DIV_ERR_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {logic c; logic l; logic e;} exp_t;
   exp_t sbq[$];
   exp_t mx;
   int   total = 0, bad = 0;

   // model: k counts edges since the last load edge
   bit m_act = 0, m_err = 0;
   int m_k = 0, m_div = 1, m_ht = 0, m_dl = 0;

   task automatic chk(input string nm, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_edge(input bit rv, input bit ld, input int dv, input int ht, input int dl);
      exp_t x;
      if (!rv) begin
         m_act = 0; m_err = 0;
      end else if (ld) begin
`ifdef CLK_DIV_ERR_EN
         if (dv == 0 || ht > dv) begin
            m_act = 0; m_err = 1;
         end else begin
            m_act = 1; m_err = 0; m_div = dv; m_ht = ht;
         end
`else
         m_div = (dv == 0) ? 1 : dv;
         m_ht  = (ht > m_div) ? m_div : ht;
         m_act = 1;
`endif
         m_dl = dl; m_k = 0;
      end else if (m_act) begin
         m_k++;
      end
      x.c = m_act && (m_k > m_dl) && (((m_k - m_dl - 1) % m_div) < m_ht);
      x.l = m_act && (m_k >= m_dl + 1 + m_div);
      x.e = m_err;
      sbq.push_back(x);
   endtask

   task automatic step(input bit rv, input bit ld, input int dv, input int ht, input int dl);
      @(negedge clk);
      reset     = rv;
      load      = ld;
      divide    = WIDTH'(dv);
      high_time = WIDTH'(ht);
      delay     = WIDTH'(dl);
      model_edge(rv, ld, dv, ht, dl);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
   endtask

   task automatic do_load(input int dv, input int ht, input int dl, input int run);
      step(1, 1, dv, ht, dl);
      idle(run);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            mx = sbq.pop_front();
            chk("clk_out", clk_out, mx.c);
            chk("LOCKED", LOCKED, mx.l);
`ifdef CLK_DIV_ERR_EN
            chk("err", err, mx.e);
`endif
         end
      end
   end

   initial begin
      int w;
      // reset held while load toggles
      for (int i = 0; i < 5; i++)
         step(0, i[0], 10, 5, 0);
      idle(3);

      do_load(10, 5, 0, 25);
      do_load(4, 1, 3, 15);
      do_load(10, 5, 0, 15);
      do_load(6, 3, 2, 15);
      do_load(3, 0, 0, 10);
      do_load(3, 3, 0, 10);
      do_load(0, 2, 0, 10);
      do_load(5, 7, 1, 12);
      do_load(4, 2, 1, 10);
      // reload on the first wrap edge: no LOCKED pulse
      do_load(4, 2, 0, 4);
      do_load(4, 2, 0, 4);
      do_load(5, 2, 0, 12);
      // load held high for several edges
      step(1, 1, 7, 2, 1);
      step(1, 1, 9, 4, 2);
      step(1, 1, 5, 3, 1);
      idle(15);

      // asynchronous reset while clk_out is high
      do_load(10, 9, 0, 3);
      @(negedge clk);
      reset = 0;
      #1;
      chk("async_clk_out", clk_out, 1'b0);
      chk("async_LOCKED", LOCKED, 1'b0);
      model_edge(0, 0, 0, 0, 0);
      step(0, 1, 8, 4, 0);
      step(1, 0, 8, 4, 0);
      idle(3);

      for (int it = 0; it < 40; it++) begin
         int dv, ht, dl;
         dv = $urandom_range(0, 12);
         ht = $urandom_range(0, 14);
         dl = $urandom_range(0, 5);
         if ($urandom_range(0, 4) == 0)
            step(1, 1, $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 5));
         do_load(dv, ht, dl, $urandom_range(0, 30));
      end

      w = 0;
      while (sbq.size() > 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      #2;
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
